// File: rtl/alu_dec.sv
// RV32I ALU with opcode/funct3 decoder. Result is combinational;
// out_q is the same result registered with a synchronous clear.
module alu_dec (
   input  logic        clk,
   input  logic        reset,
   input  logic [6:0]  opcode,
   input  logic [2:0]  funct,
   input  logic        add_rshift_type,
   input  logic        ext_op_en,
   input  logic [3:0]  ext_op,
   input  logic [31:0] A,
   input  logic [31:0] B,
   output logic [3:0]  ALUop,
   output logic [31:0] Out,
   output logic [31:0] out_q
);

   localparam logic [3:0] OP_ADD     = 4'd0;
   localparam logic [3:0] OP_SUB     = 4'd1;
   localparam logic [3:0] OP_AND     = 4'd2;
   localparam logic [3:0] OP_OR      = 4'd3;
   localparam logic [3:0] OP_XOR     = 4'd4;
   localparam logic [3:0] OP_SLT     = 4'd5;
   localparam logic [3:0] OP_SLTU    = 4'd6;
   localparam logic [3:0] OP_SLL     = 4'd7;
   localparam logic [3:0] OP_SRA     = 4'd8;
   localparam logic [3:0] OP_SRL     = 4'd9;
   localparam logic [3:0] OP_COPY_B  = 4'd10;
   localparam logic [3:0] OP_INVALID = 4'd15;

   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
   localparam logic [6:0] OPC_ITYPE  = 7'b0010011;

   logic [3:0] eff_op;
   logic [4:0] shamt;

   always_comb begin
      ALUop = OP_INVALID;
      case (opcode)
         OPC_LUI: ALUop = OP_COPY_B;
         OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH, OPC_LOAD, OPC_STORE:
            ALUop = OP_ADD;
         OPC_RTYPE, OPC_ITYPE: begin
            case (funct)
               // Immediate ADDI has no SUB form; bit 30 is part of the immediate.
               3'b000:  ALUop = (add_rshift_type && opcode == OPC_RTYPE) ? OP_SUB : OP_ADD;
               3'b001:  ALUop = OP_SLL;
               3'b010:  ALUop = OP_SLT;
               3'b011:  ALUop = OP_SLTU;
               3'b100:  ALUop = OP_XOR;
               3'b101:  ALUop = add_rshift_type ? OP_SRA : OP_SRL;
               3'b110:  ALUop = OP_OR;
               default: ALUop = OP_AND;
            endcase
         end
         default: ALUop = OP_INVALID;
      endcase
   end

   assign eff_op = ext_op_en ? ext_op : ALUop;
   assign shamt  = B[4:0];

   always_comb begin
      Out = 32'h0;
      case (eff_op)
         OP_ADD:    Out = A + B;
         OP_SUB:    Out = A - B;
         OP_AND:    Out = A & B;
         OP_OR:     Out = A | B;
         OP_XOR:    Out = A ^ B;
         OP_SLT:    Out = {31'h0, $signed(A) < $signed(B)};
         OP_SLTU:   Out = {31'h0, A < B};
         OP_SLL:    Out = A << shamt;
         OP_SRA:    Out = $unsigned($signed(A) >>> shamt);
         OP_SRL:    Out = A >> shamt;
         OP_COPY_B: Out = B;
         default:   Out = 32'h0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) out_q <= 32'h0;
      else       out_q <= Out;
   end

endmodule

// File: tb/tb_alu_dec.sv
// Directed bench for alu_dec: decode table, ALU ops, standalone sweep,
// and the registered output with synchronous reset.
module tb_alu_dec;

   logic        clk = 1'b0;
   logic        reset;
   logic [6:0]  opcode;
   logic [2:0]  funct;
   logic        add_rshift_type;
   logic        ext_op_en;
   logic [3:0]  ext_op;
   logic [31:0] A, B;
   logic [3:0]  ALUop;
   logic [31:0] Out, out_q;

   int tests = 0;
   int fails = 0;

   alu_dec dut (
      .clk(clk), .reset(reset), .opcode(opcode), .funct(funct),
      .add_rshift_type(add_rshift_type), .ext_op_en(ext_op_en), .ext_op(ext_op),
      .A(A), .B(B), .ALUop(ALUop), .Out(Out), .out_q(out_q)
   );

   always #5 clk = ~clk;

   localparam logic [6:0] LUI = 7'b0110111, AUIPC = 7'b0010111, JAL = 7'b1101111,
                          JALR = 7'b1100111, BRANCH = 7'b1100011, LOAD = 7'b0000011,
                          STORE = 7'b0100011, RTYPE = 7'b0110011, ITYPE = 7'b0010011;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Reference model written independently of the RTL (shifts by bit loops).
   function automatic logic [31:0] model(input logic [3:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
      logic [31:0] r;
      int s;
      s = int'(b[4:0]);
      r = 32'h0;
      case (op)
         4'd0: r = a + b;
         4'd1: r = a + ~b + 32'd1;
         4'd2: r = a & b;
         4'd3: r = a | b;
         4'd4: r = a ^ b;
         4'd5: r = (a[31] != b[31]) ? {31'h0, a[31]} : {31'h0, a < b};
         4'd6: r = {31'h0, a < b};
         4'd7: for (int i = 0; i < 32; i++) r[i] = (i >= s) ? a[i-s] : 1'b0;
         4'd8: for (int i = 0; i < 32; i++) r[i] = (i + s < 32) ? a[i+s] : a[31];
         4'd9: for (int i = 0; i < 32; i++) r[i] = (i + s < 32) ? a[i+s] : 1'b0;
         4'd10: r = b;
         default: r = 32'h0;
      endcase
      return r;
   endfunction

   task automatic dec(input logic [6:0] op, input logic [2:0] f, input logic art);
      opcode = op; funct = f; add_rshift_type = art;
      #1;
   endtask

   initial begin
      reset = 1'b1; opcode = LUI; funct = 3'd0; add_rshift_type = 1'b0;
      ext_op_en = 1'b0; ext_op = 4'd0; A = 32'h0; B = 32'h0;
      @(posedge clk); #1;
      check("reset_out_q", out_q, 32'h0);
      reset = 1'b0;

      // LUI / ADD-class opcodes ignore funct and bit 30
      A = 32'h80000001; B = 32'hFFFF8003;
      dec(LUI, 3'($urandom), 1'($urandom));
      check("lui_out", Out, 32'hFFFF8003);
      check("lui_op", {28'h0, ALUop}, 32'd10);
      dec(AUIPC, 3'($urandom), 1'($urandom));  check("auipc_out", Out, 32'h7FFF8004);
      dec(LOAD, 3'($urandom), 1'($urandom));   check("load_out", Out, 32'h7FFF8004);
      dec(STORE, 3'($urandom), 1'($urandom));  check("store_out", Out, 32'h7FFF8004);
      dec(BRANCH, 3'($urandom), 1'($urandom)); check("branch_out", Out, 32'h7FFF8004);
      dec(JAL, 3'b101, 1'b1);                  check("jal_op", {28'h0, ALUop}, 32'd0);
      dec(JALR, 3'b001, 1'b1);                 check("jalr_op", {28'h0, ALUop}, 32'd0);
      dec(7'b1111111, 3'b000, 1'b0);
      check("bad_opc_op", {28'h0, ALUop}, 32'd15);
      check("bad_opc_out", Out, 32'h0);

      // ADD / SUB, and ADDI ignoring bit 30
      A = 32'd5; B = 32'd7;
      dec(RTYPE, 3'b000, 1'b1); check("r_sub", Out, 32'hFFFFFFFE);
      dec(RTYPE, 3'b000, 1'b0); check("r_add", Out, 32'h0000000C);
      dec(ITYPE, 3'b000, 1'b1); check("i_addi", Out, 32'h0000000C);
      dec(RTYPE, 3'b100, 1'b0); check("r_xor", Out, 32'h00000002);
      dec(RTYPE, 3'b110, 1'b0); check("r_or", Out, 32'h00000007);
      dec(ITYPE, 3'b111, 1'b0); check("i_and", Out, 32'h00000005);

      // Shifts use B[4:0] only
      A = 32'h80000000; B = 32'hFFFFFFE5;
      dec(RTYPE, 3'b101, 1'b1); check("r_sra", Out, 32'hFC000000);
      dec(RTYPE, 3'b101, 1'b0); check("r_srl", Out, 32'h04000000);
      dec(ITYPE, 3'b101, 1'b1); check("i_srai", Out, 32'hFC000000);
      dec(RTYPE, 3'b001, 1'b0); check("r_sll", Out, 32'h00000000);
      A = 32'h00000003; B = 32'h0000001F;
      dec(RTYPE, 3'b001, 1'b0); check("r_sll31", Out, 32'h80000000);

      // Signed vs unsigned compare
      A = 32'hFFFFFFFF; B = 32'd1;
      dec(RTYPE, 3'b010, 1'b0); check("slt_neg", Out, 32'd1);
      dec(RTYPE, 3'b011, 1'b0); check("sltu_big", Out, 32'd0);
      B = 32'hFFFFFFFF;
      dec(RTYPE, 3'b010, 1'b0); check("slt_eq", Out, 32'd0);
      dec(ITYPE, 3'b011, 1'b0); check("sltu_eq", Out, 32'd0);

      // Standalone ALU: ext_op overrides decode, ALUop keeps decoding
      ext_op_en = 1'b1;
      dec(LUI, 3'b000, 1'b0);
      for (int op = 0; op <= 10; op++) begin
         for (int k = 0; k < 100; k++) begin
            ext_op = 4'(op);
            A = $urandom; B = $urandom;
            if (k == 0) B[4:0] = 5'd0;
            #1;
            check($sformatf("ext_op%0d", op), Out, model(4'(op), A, B));
         end
      end
      check("ext_aluop_indep", {28'h0, ALUop}, 32'd10);
      A = 32'h12345678; B = 32'h9ABCDEF0;
      ext_op = 4'd12; #1; check("ext_op12", Out, 32'h0);
      ext_op = 4'd15; #1; check("ext_op15", Out, 32'h0);
      ext_op = 4'd11; #1; check("ext_op11", Out, 32'h0);
      ext_op_en = 1'b0;

      // Register latency and synchronous reset
      @(negedge clk);
      A = 32'd1; B = 32'd2; opcode = RTYPE; funct = 3'b000; add_rshift_type = 1'b0;
      @(posedge clk); #1;
      check("reg_add", out_q, 32'd3);
      @(negedge clk); reset = 1'b1;
      @(posedge clk); #1;
      check("reg_reset", out_q, 32'h0);
      check("reset_out_comb", Out, 32'd3);
      check("reset_aluop", {28'h0, ALUop}, 32'd0);
      @(negedge clk); reset = 1'b0; A = 32'd10;
      @(posedge clk); #1;
      check("reg_resume", out_q, 32'd12);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
